volume_meter: RTL and testbench
===============================

VOLUME_METER -- requirements
Module: volume_meter

Interface
REQ-001 SHALL have parameter MAX_HEIGHT, default 300, giving full-scale bar height in pixels.
REQ-002 SHALL have parameter DECAY_STEP, default 4, giving pixels removed per frame while decaying.
REQ-003 SHALL have parameter HOLD_FRAMES, default 30, giving frames the peak is held before decay starts.
REQ-004 Clk  input  1  system clock; one clock domain, all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 sample_valid  input  1  one-cycle strobe; sample_l/sample_r are valid this cycle.
REQ-007 sample_l  input  16  signed two's-complement left audio sample.
REQ-008 sample_r  input  16  signed two's-complement right audio sample.
REQ-009 frame_start  input  1  one-cycle pulse marking the start of a video frame (vsync edge).
REQ-010 bar_height  output  16  display bar height in pixels, range 0..MAX_HEIGHT-1, fed to the color mapper.
REQ-011 height_valid  output  1  one-cycle pulse when bar_height has just been updated.
REQ-012 clip  output  1  high for one frame after any sample magnitude reached 32767.

Function
REQ-013 SHALL compute mag = |sample| per channel, saturating -32768 to 32767, on every sample_valid.
REQ-014 SHALL keep the 15-bit accumulator acc = max(acc, mag_l, mag_r) over all valid samples in the current frame.
REQ-015 SHALL keep the clip accumulator clip_acc set when any mag equals 32767 in the current frame.
REQ-016 On frame_start (cycle N): frame_peak <= acc, frame_clip <= clip_acc, then acc and clip_acc clear.
REQ-017 If sample_valid coincides with frame_start, that sample SHALL count toward the new frame only, seeding acc and clip_acc.
REQ-018 Cycle N+1: SHALL register target = (frame_peak * MAX_HEIGHT) >> 15, using a 32-bit product and no rounding.
REQ-019 Cycle N+2: SHALL update bar_height and clip (clip <= frame_clip), and pulse height_valid for exactly one cycle.
REQ-020 SHALL use states HOLD and DECAY, evaluated only in update cycle N+2.
REQ-021 Attack, when target >= bar_height in any state: bar_height <= target, hold_cnt <= HOLD_FRAMES, state <= HOLD, or DECAY if HOLD_FRAMES = 0.
REQ-022 HOLD with target < bar_height: bar_height unchanged, hold_cnt decrements, and state <= DECAY when hold_cnt reaches 0.
REQ-023 DECAY with target < bar_height: bar_height <= max(target, bar_height - DECAY_STEP), saturating at 0 with no underflow.
REQ-024 A frame_start arriving while the N+1/N+2 pipeline is busy SHALL be ignored; frame spacing is guaranteed to be at least 3 cycles.
REQ-025 Between updates, bar_height and clip SHALL remain stable; the outputs are registered and no combinational path runs from inputs to outputs.

Reset
REQ-026 Reset SHALL clear acc, clip_acc, frame_peak, target, hold_cnt, bar_height, clip and height_valid to 0, and set state to DECAY.
REQ-027 Reset asserted mid-frame or mid-pipeline SHALL discard the pending update; no height_valid pulse follows.
REQ-028 Reset SHALL take priority over simultaneous sample_valid and frame_start.

Verification
REQ-029 Samples +16384 and -100, then frame_start at cycle N -> bar_height = 150 and height_valid = 1 at N+2, clip = 0.
REQ-030 Sample -32768, then frame_start -> bar_height = 299 and clip = 1; the next frame with silence -> clip = 0.
REQ-031 Peak reaches 150, then silent frames -> bar_height holds at 150 for 30 updates, then steps 146, 142, ..., 2, 0 and stays at 0.
REQ-032 While decaying at 100, a frame with peak 8192 (target 75) -> bar_height 96; a frame with peak 16384 (target 150) -> bar_height 150 and the hold restarts.
REQ-033 sample_valid carrying 32767 in the same cycle as frame_start -> the closing frame excludes the sample, and the following frame reports 299 with clip = 1.
REQ-034 Reset asserted at cycle N+1 after frame_start -> no height_valid pulse, and bar_height = 0 from the next cycle.

Source files
------------

// File: rtl/volume_meter.sv
// Stereo peak volume meter: per-frame peak detection, scaling to a bar height,
// and hold/decay ballistics updated two cycles after each accepted frame start.
module volume_meter #(
  parameter int unsigned MAX_HEIGHT  = 300,
  parameter int unsigned DECAY_STEP  = 4,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sample_valid_i,
  input  logic [15:0] sample_l_i,
  input  logic [15:0] sample_r_i,
  input  logic        frame_start_i,
  output logic [15:0] bar_height_o,
  output logic        height_valid_o,
  output logic        clip_o
);

  typedef enum logic {
    HOLD  = 1'b0,
    DECAY = 1'b1
  } state_e;

  // -32768 has no positive counterpart, so it saturates to full scale.
  function automatic logic [14:0] absSat(input logic [15:0] s);
    if (!s[15])               return s[14:0];
    else if (s[14:0] == '0)   return 15'h7FFF;
    else                      return (~s[14:0]) + 15'd1;
  endfunction

  logic [14:0] magL, magR, sampleMax;
  logic        sampleClip, frameTake;

  logic [14:0] acc_q, acc_d;
  logic        clipAcc_q, clipAcc_d;
  logic [14:0] framePeak_q, framePeak_d;
  logic        frameClip_q, frameClip_d;
  logic        stage1_q, stage1_d;
  logic        stage2_q, stage2_d;
  logic [15:0] target_q, target_d;

  logic [15:0] barHeight_q, barHeight_d;
  logic        clip_q, clip_d;
  logic        heightValid_q, heightValid_d;
  logic [15:0] holdCnt_q, holdCnt_d;
  state_e      state_q, state_d;
  logic [15:0] decayed;

  assign magL       = absSat(sample_l_i);
  assign magR       = absSat(sample_r_i);
  assign sampleMax  = (magL > magR) ? magL : magR;
  assign sampleClip = sample_valid_i && ((magL == 15'h7FFF) || (magR == 15'h7FFF));
  assign frameTake  = frame_start_i && !stage1_q && !stage2_q;

  // Peak accumulation, frame capture and target scaling pipeline.
  always_comb begin
    acc_d       = acc_q;
    clipAcc_d   = clipAcc_q;
    framePeak_d = framePeak_q;
    frameClip_d = frameClip_q;
    stage1_d    = frameTake;
    stage2_d    = stage1_q;
    target_d    = target_q;
    if (frameTake) begin
      framePeak_d = acc_q;
      frameClip_d = clipAcc_q;
      acc_d       = sample_valid_i ? sampleMax : 15'd0;
      clipAcc_d   = sampleClip;
    end else if (sample_valid_i) begin
      acc_d     = (sampleMax > acc_q) ? sampleMax : acc_q;
      clipAcc_d = clipAcc_q | sampleClip;
    end
    if (stage1_q) begin
      target_d = 16'((32'(framePeak_q) * 32'(MAX_HEIGHT)) >> 15);
    end
  end

  assign decayed = (barHeight_q >= 16'(DECAY_STEP)) ? (barHeight_q - 16'(DECAY_STEP)) : 16'd0;

  // Hold/decay ballistics, only evaluated in the update cycle.
  always_comb begin
    state_d       = state_q;
    holdCnt_d     = holdCnt_q;
    barHeight_d   = barHeight_q;
    clip_d        = clip_q;
    heightValid_d = 1'b0;
    if (stage2_q) begin
      heightValid_d = 1'b1;
      clip_d        = frameClip_q;
      if (target_q >= barHeight_q) begin
        barHeight_d = target_q;
        holdCnt_d   = 16'(HOLD_FRAMES);
        state_d     = (HOLD_FRAMES == 0) ? DECAY : HOLD;
      end else if (state_q == HOLD) begin
        if (holdCnt_q <= 16'd1) begin
          holdCnt_d = 16'd0;
          state_d   = DECAY;
        end else begin
          holdCnt_d = holdCnt_q - 16'd1;
        end
      end else begin
        barHeight_d = (target_q > decayed) ? target_q : decayed;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q         <= '0;
      clipAcc_q     <= 1'b0;
      framePeak_q   <= '0;
      frameClip_q   <= 1'b0;
      stage1_q      <= 1'b0;
      stage2_q      <= 1'b0;
      target_q      <= '0;
      barHeight_q   <= '0;
      clip_q        <= 1'b0;
      heightValid_q <= 1'b0;
      holdCnt_q     <= '0;
      state_q       <= DECAY;
    end else begin
      acc_q         <= acc_d;
      clipAcc_q     <= clipAcc_d;
      framePeak_q   <= framePeak_d;
      frameClip_q   <= frameClip_d;
      stage1_q      <= stage1_d;
      stage2_q      <= stage2_d;
      target_q      <= target_d;
      barHeight_q   <= barHeight_d;
      clip_q        <= clip_d;
      heightValid_q <= heightValid_d;
      holdCnt_q     <= holdCnt_d;
      state_q       <= state_d;
    end
  end

  assign bar_height_o   = barHeight_q;
  assign height_valid_o = heightValid_q;
  assign clip_o         = clip_q;

endmodule

// File: tb/tb_volume_meter.sv
// Directed bench for volume_meter: reset, peak scaling, clip flag, hold/decay
// ballistics, coincident sample/frame start, busy-pipeline and mid-pipeline reset.
module tb_volume_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sampleValid;
  logic [15:0] sampleL, sampleR;
  logic        frameStart;
  logic [15:0] barHeight;
  logic        heightValid;
  logic        clip;

  int total = 0;
  int bad   = 0;

  volume_meter #(
    .MAX_HEIGHT (300),
    .DECAY_STEP (4),
    .HOLD_FRAMES(30)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .sample_valid_i(sampleValid),
    .sample_l_i    (sampleL),
    .sample_r_i    (sampleR),
    .frame_start_i (frameStart),
    .bar_height_o  (barHeight),
    .height_valid_o(heightValid),
    .clip_o        (clip)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then return them to idle.
  task automatic applyStimulus(input logic v, input logic [15:0] l, input logic [15:0] r,
                               input logic fs);
    sampleValid = v;
    sampleL     = l;
    sampleR     = r;
    frameStart  = fs;
    tick();
    sampleValid = 1'b0;
    sampleL     = '0;
    sampleR     = '0;
    frameStart  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset bar", 32'(barHeight), 32'd0);
    checkOutput("reset hv", 32'(heightValid), 32'd0);
    checkOutput("reset clip", 32'(clip), 32'd0);
  endtask

  // Frame start (optionally with a coincident sample), then check the update two edges later.
  task automatic doFrame(input string tag, input logic v, input logic [15:0] l,
                         input logic [15:0] r, input int expBar, input logic expClip);
    applyStimulus(v, l, r, 1'b1);
    checkOutput({tag, " hv N"}, 32'(heightValid), 32'd0);
    tick();
    checkOutput({tag, " hv N+1"}, 32'(heightValid), 32'd0);
    tick();
    checkOutput({tag, " hv N+2"}, 32'(heightValid), 32'd1);
    checkOutput({tag, " bar"}, 32'(barHeight), 32'(expBar));
    checkOutput({tag, " clip"}, 32'(clip), 32'(expClip));
    tick();
    checkOutput({tag, " hv N+3"}, 32'(heightValid), 32'd0);
    checkOutput({tag, " bar stable"}, 32'(barHeight), 32'(expBar));
  endtask

  initial begin
    reset       = 1'b1;
    sampleValid = 1'b0;
    sampleL     = '0;
    sampleR     = '0;
    frameStart  = 1'b0;
    $display("[TB] starting");
    doReset();

    // 16384 and -100 -> target 150, then 30 held frames and a 4-px decay to zero.
    applyStimulus(1'b1, 16'd16384, 16'd0, 1'b0);
    applyStimulus(1'b1, -16'sd100, -16'sd100, 1'b0);
    doFrame("peak150", 1'b0, 16'd0, 16'd0, 150, 1'b0);
    for (int i = 0; i < 30; i++) doFrame("hold150", 1'b0, 16'd0, 16'd0, 150, 1'b0);
    for (int e = 146; e >= 2; e -= 4) doFrame("decay", 1'b0, 16'd0, 16'd0, e, 1'b0);
    doFrame("floor0", 1'b0, 16'd0, 16'd0, 0, 1'b0);
    doFrame("stay0", 1'b0, 16'd0, 16'd0, 0, 1'b0);

    // -32768 saturates to full scale and clips; the following silent frame clears clip.
    applyStimulus(1'b1, 16'h0000, 16'h8000, 1'b0);
    doFrame("fullscale", 1'b0, 16'd0, 16'd0, 299, 1'b1);
    doFrame("clipclear", 1'b0, 16'd0, 16'd0, 299, 1'b0);

    // Reach 104, hold, decay to 100, then a small peak decays and a large one re-attacks.
    doReset();
    applyStimulus(1'b1, 16'd11360, 16'd0, 1'b0);
    doFrame("peak104", 1'b0, 16'd0, 16'd0, 104, 1'b0);
    for (int i = 0; i < 30; i++) doFrame("hold104", 1'b0, 16'd0, 16'd0, 104, 1'b0);
    doFrame("decay100", 1'b0, 16'd0, 16'd0, 100, 1'b0);
    applyStimulus(1'b1, 16'd0, 16'd8192, 1'b0);
    doFrame("tgt75", 1'b0, 16'd0, 16'd0, 96, 1'b0);
    applyStimulus(1'b1, -16'sd16384, 16'd0, 1'b0);
    doFrame("reattack", 1'b0, 16'd0, 16'd0, 150, 1'b0);
    doFrame("holdagain", 1'b0, 16'd0, 16'd0, 150, 1'b0);

    // Reset at the edge after frame start discards the pending update.
    applyStimulus(1'b1, 16'd32767, 16'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset bar", 32'(barHeight), 32'd0);
    checkOutput("midreset hv", 32'(heightValid), 32'd0);
    tick();
    checkOutput("midreset hv N+2", 32'(heightValid), 32'd0);
    tick();
    checkOutput("midreset hv N+3", 32'(heightValid), 32'd0);
    checkOutput("midreset clip", 32'(clip), 32'd0);

    // A frame start while the pipeline is busy is ignored; its sample joins the open frame.
    applyStimulus(1'b1, 16'd16384, 16'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    applyStimulus(1'b1, 16'd32767, 16'd0, 1'b1);
    tick();
    checkOutput("busy hv", 32'(heightValid), 32'd1);
    checkOutput("busy bar", 32'(barHeight), 32'd150);
    checkOutput("busy clip", 32'(clip), 32'd0);
    tick();
    checkOutput("busy hv after", 32'(heightValid), 32'd0);
    doFrame("busysample", 1'b0, 16'd0, 16'd0, 299, 1'b1);

    // A sample coincident with frame start belongs only to the new frame.
    doReset();
    doFrame("coincident", 1'b1, 16'd32767, 16'd0, 0, 1'b0);
    doFrame("coinnext", 1'b0, 16'd0, 16'd0, 299, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
